// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester handshakes and the data-memory
// port used by dmem_arbiter.
//   Requester side : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 (in to arbiter)
//                    done0/done1, rdata0/rdata1, err0/err1 (out of arbiter)
//   Memory side    : mem_addr, mem_read, mem_write, mem_wdata (out of arbiter)
//                    mem_rdata (in to arbiter, combinational from mem_addr)
//   Status         : conflict_cnt (out of arbiter)
// modport slave  : the arbiter's view.
// modport master : the environment's view (requesters + memory).
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          err0;
    logic          err1;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] conflict_cnt;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output done0, done1, rdata0, rdata1, err0, err1,
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  done0, done1, rdata0, rdata1, err0, err1,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port (async read, write on posedge)
// between the CPU load/store path (port 0) and the debug/loader path (port 1).
// Each access runs IDLE -> ACCESS -> DONE, so one access per three cycles.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : dmem_arbiter_if.slave (requester handshakes, memory port, conflict_cnt)
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN defined   -> port 0 always wins a tie
//   DMEM_ARB_FIXED_PRIO_EN undefined -> round-robin on ties (default)
module dmem_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 52,
    parameter int unsigned CW    = 16
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic          r_sel;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_done0;
    logic          r_done1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic [CW-1:0] r_cnt;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic          r_last;
`endif

    logic          w_any_req;
    logic          w_both_req;
    logic          w_grant1;
    logic          w_in_range;
    logic [DW-1:0] w_rdata_cap;
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_read;
    logic          w_mem_write;
    logic [DW-1:0] w_mem_wdata;

    assign w_any_req  = bus.req0 | bus.req1;
    assign w_both_req = bus.req0 & bus.req1;
    assign w_in_range = (r_addr < DEPTH_A);
    // Writes and out-of-range accesses return zero rather than whatever the bus shows.
    assign w_rdata_cap = (!r_we && w_in_range) ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_grant1 = bus.req1 & ~bus.req0;
`else
    // On a tie the winner is the port that did not win the previous tie.
    assign w_grant1 = bus.req1 & (~bus.req0 | ~r_last);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_any_req ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Memory-side outputs, decoded from registered state only
    always_comb begin
        w_mem_addr  = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_wdata = '0;
        if (r_state == S_ACCESS) begin
            w_mem_addr  = r_addr;
            w_mem_wdata = r_wdata;
            w_mem_read  = !r_we && w_in_range;
            // rst gates the write so a reset landing on ACCESS never commits it.
            w_mem_write = r_we && w_in_range && !rst;
        end
    end

    // Request latch, completion registers and conflict counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_cnt    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_last   <= 1'b1;
`endif
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel   <= w_grant1;
                        r_we    <= w_grant1 ? bus.we1    : bus.we0;
                        r_addr  <= w_grant1 ? bus.addr1  : bus.addr0;
                        r_wdata <= w_grant1 ? bus.wdata1 : bus.wdata0;
                    end
                    if (w_both_req) begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        r_last <= w_grant1;
`endif
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_ACCESS: begin
                    // done/err/rdata are registered here so they are valid during DONE.
                    if (r_sel) begin
                        r_done1  <= 1'b1;
                        r_err1   <= !w_in_range;
                        r_rdata1 <= w_rdata_cap;
                    end else begin
                        r_done0  <= 1'b1;
                        r_err0   <= !w_in_range;
                        r_rdata0 <= w_rdata_cap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done0        = r_done0;
    assign bus.done1        = r_done1;
    assign bus.err0         = r_err0;
    assign bus.err1         = r_err1;
    assign bus.rdata0       = r_rdata0;
    assign bus.rdata1       = r_rdata1;
    assign bus.conflict_cnt = r_cnt;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_read     = w_mem_read;
    assign bus.mem_write    = w_mem_write;
    assign bus.mem_wdata    = w_mem_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Main instance (CW=16) is backed by a small behavioural memory; a second
// instance (CW=4) with both requests tied high exercises counter saturation.
module tb_dmem_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 52;
    localparam int unsigned CW    = 16;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam int MAXAGE = 200;
`else
    localparam int MAXAGE = 12;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();
    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_arbiter_if #(.AW(AW), .DW(DW), .CW(4)) bus2 ();
    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(4)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );
    assign bus2.req0      = 1'b1;
    assign bus2.req1      = 1'b1;
    assign bus2.we0       = 1'b0;
    assign bus2.we1       = 1'b0;
    assign bus2.addr0     = '0;
    assign bus2.addr1     = '0;
    assign bus2.wdata0    = '0;
    assign bus2.wdata1    = '0;
    assign bus2.mem_rdata = '0;

    // Behavioural data memory: async read, write on rising edge
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.mem_write === 1'b1 && bus.mem_addr < 64) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = (bus.mem_addr < 64) ? mem[bus.mem_addr[5:0]] : '0;

    int wr_pulses = 0;
    always @(negedge clk) begin
        if (bus.mem_write === 1'b1) wr_pulses++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic done_of(input int p);
        return (p == 0) ? bus.done0 : bus.done1;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? bus.err0 : bus.err1;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? bus.rdata0 : bus.rdata1;
    endfunction

    task automatic drive(input int p, input logic rq, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = rq; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = rq; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // One isolated access on port p; returns what was observed.
    task automatic run_access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic er, output int lat,
                              output logic ar, output logic aw, output logic [31:0] aa,
                              output logic od);
        drive(p, 1'b1, w, a, d);
        lat = 0; ar = 1'b0; aw = 1'b0; aa = '0; od = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                ar = bus.mem_read; aw = bus.mem_write; aa = bus.mem_addr;
            end
            if (done_of(1 - p) !== 1'b0) od = 1'b1;
            if (done_of(p) === 1'b1) break;
        end
        check($sformatf("p%0d_done_seen", p), 32'(done_of(p)), 32'd1);
        rd = rdata_of(p);
        er = err_of(p);
        drive(p, 1'b0, w, a, d);
        @(posedge clk); #1;
        check($sformatf("p%0d_done_one_cycle", p), 32'(done_of(p)), 32'd0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    logic [31:0] exp_last [2];
    logic [31:0] mdl [0:63];

    initial begin
        logic [31:0] rd, aa, erd;
        logic        er, ar, aw, od, inr;
        int          lat, wp0;
        int          ev_p[$], ev_c[$];
        int          exp_port [4];
        logic        pend [2];
        logic        pwe [2];
        logic [31:0] pad [2], pwd [2];
        int          age [2];

        vt[0] = '{1, 1'b1, 32'd5,          32'h0000_00AA, 32'h0,         1'b0};
        vt[1] = '{1, 1'b0, 32'd5,          32'h0,         32'h0000_00AA, 1'b0};
        vt[2] = '{0, 1'b1, 32'd7,          32'hDEAD_BEEF, 32'h0,         1'b0};
        vt[3] = '{0, 1'b0, 32'd7,          32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[4] = '{1, 1'b1, 32'd52,         32'h0000_1234, 32'h0,         1'b1};
        vt[5] = '{1, 1'b0, 32'd52,         32'h0,         32'h0,         1'b1};
        vt[6] = '{0, 1'b1, 32'd51,         32'h5A5A_5A5A, 32'h0,         1'b0};
        vt[7] = '{0, 1'b0, 32'd51,         32'h0,         32'h5A5A_5A5A, 1'b0};
        vt[8] = '{0, 1'b1, 32'd3,          32'h0000_0033, 32'h0,         1'b0};
        vt[9] = '{1, 1'b0, 32'hFFFF_FFFF,  32'h0,         32'h0,         1'b1};

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1; rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done0", 32'(bus.done0), 0);
        check("rst_done1", 32'(bus.done1), 0);
        check("rst_err0", 32'(bus.err0), 0);
        check("rst_err1", 32'(bus.err1), 0);
        check("rst_rdata0", bus.rdata0, 0);
        check("rst_rdata1", bus.rdata1, 0);
        check("rst_cnt", 32'(bus.conflict_cnt), 0);
        check("rst_mem_read", 32'(bus.mem_read), 0);
        check("rst_mem_write", 32'(bus.mem_write), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        rst = 1'b0;
        exp_last[0] = '0; exp_last[1] = '0;

        // Table of isolated accesses
        for (int i = 0; i < NV; i++) begin
            wp0 = wr_pulses;
            run_access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat, ar, aw, aa, od);
            inr = (vt[i].addr < DEPTH);
            check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("v%0d_mem_read", i), 32'(ar), 32'(!vt[i].we && inr));
            check($sformatf("v%0d_mem_write", i), 32'(aw), 32'(vt[i].we && inr));
            check($sformatf("v%0d_mem_addr", i), aa, vt[i].addr);
            check($sformatf("v%0d_write_pulses", i), 32'(wr_pulses - wp0), 32'(vt[i].we && inr));
            check($sformatf("v%0d_other_done", i), 32'(od), 0);
            check($sformatf("v%0d_other_rdata_held", i), rdata_of(1 - vt[i].port), exp_last[1 - vt[i].port]);
            exp_last[vt[i].port] = vt[i].exp_rd;
        end

        // Both requests held from reset: grant order and conflict count
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 32'd7, '0);
        drive(1, 1'b1, 1'b0, 32'd5, '0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus.done0 === 1'b1) begin ev_p.push_back(0); ev_c.push_back(c); end
            if (bus.done1 === 1'b1) begin ev_p.push_back(1); ev_c.push_back(c); end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_port = '{0, 0, 0, 0};
`else
        exp_port = '{0, 1, 0, 1};
`endif
        check("tie_done_count", 32'(ev_p.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_grant%0d_port", i), 32'((i < ev_p.size()) ? ev_p[i] : -1), 32'(exp_port[i]));
            check($sformatf("tie_grant%0d_cycle", i), 32'((i < ev_c.size()) ? ev_c[i] : -1), 32'(2 + 3 * i));
        end
        check("tie_conflict_cnt", 32'(bus.conflict_cnt), 32'd4);
        check("tie_rdata0", bus.rdata0, 32'hDEAD_BEEF);
`ifndef DMEM_ARB_FIXED_PRIO_EN
        check("tie_rdata1", bus.rdata1, 32'h0000_00AA);
`endif

        // Reset landing on the ACCESS cycle of a write
        @(posedge clk); #1;
        wp0 = wr_pulses;
        drive(0, 1'b1, 1'b1, 32'd3, 32'h0000_0099);
        @(posedge clk); #1;
        check("rstmid_write_before_rst", 32'(bus.mem_write), 1);
        rst = 1'b1;
        #1;
        check("rstmid_write_gated", 32'(bus.mem_write), 0);
        @(posedge clk); #1;
        check("rstmid_done0", 32'(bus.done0), 0);
        check("rstmid_done1", 32'(bus.done1), 0);
        check("rstmid_err0", 32'(bus.err0), 0);
        check("rstmid_rdata0", bus.rdata0, 0);
        check("rstmid_rdata1", bus.rdata1, 0);
        check("rstmid_cnt", 32'(bus.conflict_cnt), 0);
        check("rstmid_mem_read", 32'(bus.mem_read), 0);
        check("rstmid_mem_addr", bus.mem_addr, 0);
        check("rstmid_mem_wdata", bus.mem_wdata, 0);
        check("rstmid_mem3", mem[3], 32'h0000_0033);
        check("rstmid_write_pulses", 32'(wr_pulses - wp0), 0);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("rstmid_no_done", 32'(bus.done0 | bus.done1), 0);
        end

        // Seed the addresses used by the random phase
        for (int a = 0; a < 12; a++) begin
            logic [31:0] sa, sd;
            sa = (a < 8) ? 32'(a) : 32'(40 + a);
            sd = $urandom;
            run_access(a % 2, 1'b1, sa, sd, rd, er, lat, ar, aw, aa, od);
            mdl[sa[5:0]] = sd;
        end

        // Random concurrent traffic against a transaction-level memory model:
        // completions are serialised, so applying them in done order is exact.
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; age[p] = 0; pwe[p] = 1'b0; pad[p] = '0; pwd[p] = '0;
        end
        for (int cyc = 0; cyc < 400 || ((pend[0] || pend[1]) && cyc < 500); cyc++) begin
            if (cyc < 400) begin
                for (int p = 0; p < 2; p++) begin
                    if (!pend[p] && $urandom_range(0, 2) == 0) begin
                        int r;
                        r = int'($urandom_range(0, 15));
                        pend[p] = 1'b1;
                        age[p]  = 0;
                        pwe[p]  = 1'($urandom_range(0, 1));
                        pad[p]  = (r < 8) ? 32'(r) : 32'(40 + r);
                        pwd[p]  = $urandom;
                        drive(p, 1'b1, pwe[p], pad[p], pwd[p]);
                    end
                end
            end
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (done_of(p) === 1'b1) begin
                    check($sformatf("rnd_p%0d_done_was_pending", p), 32'(pend[p]), 1);
                    inr = (pad[p] < DEPTH);
                    erd = (!pwe[p] && inr) ? mdl[pad[p][5:0]] : '0;
                    check($sformatf("rnd_p%0d_rdata_a%0d", p, pad[p]), rdata_of(p), erd);
                    check($sformatf("rnd_p%0d_err_a%0d", p, pad[p]), 32'(err_of(p)), 32'(!inr));
                    if (pwe[p] && inr) mdl[pad[p][5:0]] = pwd[p];
                    pend[p] = 1'b0;
                    drive(p, 1'b0, 1'b0, '0, '0);
                end else if (pend[p]) begin
                    age[p]++;
                    if (age[p] > MAXAGE) begin
                        check($sformatf("rnd_p%0d_wait_bound", p), 32'(age[p]), 32'(MAXAGE));
                        pend[p] = 1'b0;
                        drive(p, 1'b0, 1'b0, '0, '0);
                    end
                end
            end
        end
        check("rnd_drained", 32'(pend[0] | pend[1]), 0);

        // Saturation on the CW=4 instance: a conflicting IDLE edge every third cycle
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            @(posedge clk); #1;
            if (e == 30) check("sat_cnt_after_10", 32'(bus2.conflict_cnt), 32'd10);
            if (e == 42) check("sat_cnt_after_14", 32'(bus2.conflict_cnt), 32'd14);
            if (e == 63) check("sat_cnt_held", 32'(bus2.conflict_cnt), 32'd15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
